// File: rtl/cpu_port_fifo_if.sv
// rtl/cpu_port_fifo_if.sv - CPU output-port FIFO bus: write strobe, drain handshake, status.
// Optional out_parity is present when CPU_PORT_PARITY_EN is defined.
interface cpu_port_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             ovf;
    logic             ovf_clr;
`ifdef CPU_PORT_PARITY_EN
    logic             out_parity;
`endif

    modport slave (
        input  wr_en, wr_data, out_ready, ovf_clr,
        output out_data, out_valid, full, empty, count, ovf
`ifdef CPU_PORT_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output wr_en, wr_data, out_ready, ovf_clr,
        input  out_data, out_valid, full, empty, count, ovf
`ifdef CPU_PORT_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/cpu_port_fifo.sv
// rtl/cpu_port_fifo.sv - FWFT queue buffering CPU output-port writes for a slow consumer.
// Define CPU_PORT_PARITY_EN to add out_parity (even parity over the head entry).
module cpu_port_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    cpu_port_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf_q;
    logic             is_full;
    logic             is_empty;
    logic             pop;
    logic             push;
    logic             drop;

    assign is_full  = (cnt == (AW+1)'(DEPTH));
    assign is_empty = (cnt == '0);

    // A full queue still accepts a write when the head leaves on the same edge.
    assign pop  = !is_empty && bus.out_ready;
    assign push = bus.wr_en && (!is_full || pop);
    assign drop = bus.wr_en && is_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.out_data  = is_empty ? '0 : mem[rd_ptr];
    assign bus.out_valid = !is_empty;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.count     = cnt;
    assign bus.ovf       = ovf_q;

`ifdef CPU_PORT_PARITY_EN
    assign bus.out_parity = ^bus.out_data;
`endif
endmodule

// File: tb/tb_cpu_port_fifo.sv
// tb/tb_cpu_port_fifo.sv - directed self-checking bench for cpu_port_fifo.
module tb_cpu_port_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_port_fifo_if #(.WIDTH(4), .DEPTH(8)) bus ();

    cpu_port_fifo #(.WIDTH(4), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_data;
        logic       out_ready;
        logic [3:0] e_data;
        logic       e_valid;
        logic [3:0] e_count;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] wd, input logic rdy, input logic clr);
        bus.wr_en     = we;
        bus.wr_data   = wd;
        bus.out_ready = rdy;
        bus.ovf_clr   = clr;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0);

        // Ordering, handshake hold, empty write+ready and 1-cycle latency.
        vecs[0] = '{1'b1, 4'h1, 1'b0, 4'h1, 1'b1, 4'd1};
        vecs[1] = '{1'b1, 4'h2, 1'b0, 4'h1, 1'b1, 4'd2};
        vecs[2] = '{1'b1, 4'h3, 1'b0, 4'h1, 1'b1, 4'd3};
        vecs[3] = '{1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 4'd2};
        vecs[4] = '{1'b0, 4'h0, 1'b1, 4'h3, 1'b1, 4'd1};
        vecs[5] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'd0};
        vecs[6] = '{1'b1, 4'h5, 1'b1, 4'h5, 1'b1, 4'd1};
        vecs[7] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'd0};

        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data), 32'd0);
        chk("rst_ovf",   32'(bus.ovf), 32'd0);
        #10 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].out_ready, 1'b0);
            step();
            chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].e_data));
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vecs[i].e_count));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty),     32'(vecs[i].e_count == 4'd0));
        end

        // Asynchronous reset with three entries queued, checked before any edge.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 9), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",  32'(bus.out_data), 32'd0);
        chk("mid_rst_ovf",   32'(bus.ovf), 32'd0);
        #1 rst = 1'b0;

        // Overflow: nine writes, the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0);
            step();
        end
        chk("ovf_full",  32'(bus.full), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_flag",  32'(bus.ovf), 32'd1);
        // Dropped write and clear on the same edge: set wins.
        drive(1'b1, 4'h9, 1'b0, 1'b1);
        step();
        chk("ovf_set_wins", 32'(bus.ovf), 32'd1);
        chk("ovf_count2",   32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0);
            chk($sformatf("ovf_drain%0d", i), 32'(bus.out_data), 32'(i));
            step();
        end
        chk("ovf_drained", 32'(bus.empty), 32'd1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        step();
        chk("ovf_clr", 32'(bus.ovf), 32'd0);

        // Full queue with simultaneous write and pop.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0);
            step();
        end
        chk("fs_full", 32'(bus.full), 32'd1);
        drive(1'b1, 4'hA, 1'b1, 1'b0);
        step();
        chk("fs_count", 32'(bus.count), 32'd8);
        chk("fs_ovf",   32'(bus.ovf), 32'd0);
        for (int i = 1; i < 9; i++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0);
            chk($sformatf("fs_drain%0d", i), 32'(bus.out_data), (i == 8) ? 32'hA : 32'(i));
            step();
        end
        chk("fs_empty", 32'(bus.empty), 32'd1);

        // Pointer roll-over: one entry in flight, write and read every cycle.
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        step();
        for (int k = 1; k < 20; k++) begin
            drive(1'b1, 4'(k % 16), 1'b1, 1'b0);
            chk($sformatf("wrap_head%0d", k), 32'(bus.out_data), 32'((k - 1) % 16));
            step();
            chk($sformatf("wrap_count%0d", k), 32'(bus.count), 32'd1);
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        chk("wrap_last", 32'(bus.out_data), 32'h3);
        step();
        chk("wrap_empty", 32'(bus.empty), 32'd1);

`ifdef CPU_PORT_PARITY_EN
        chk("par_empty", 32'(bus.out_parity), 32'd0);
        drive(1'b1, 4'h7, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h3, 1'b0, 1'b0);
        step();
        chk("par_h7", 32'(bus.out_parity), 32'd1);
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        step();
        chk("par_h3", 32'(bus.out_parity), 32'd0);
        step();
`endif

        drive(1'b0, 4'h0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
